// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared state encoding and select geometry for the digit scanner
package digit_scan_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;
  localparam int SEL_W = 2;
  localparam int NUM_IDX = 4;
endpackage

// File: rtl/digit_scan_ctrl_next_sel.sv
// scan_next_sel: circular lowest-set-bit search starting just above cur
module scan_next_sel
  import digit_scan_pkg::*;
(
  input  logic [SEL_W-1:0]   cur,
  input  logic [NUM_IDX-1:0] mask,
  output logic [SEL_W-1:0]   nxt,
  output logic               wrap,
  output logic               any
);
  always_comb begin
    nxt = cur;
    for (int k = NUM_IDX; k >= 1; k--)
      if (mask[cur + SEL_W'(k)]) nxt = cur + SEL_W'(k);
    any = |mask;
    wrap = any && (nxt <= cur);
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: round-robin decoder select sequencer with dwell, blanking and frame pulse
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_IDX-1:0] mask,
  output logic               a0,
  output logic               a1,
  output logic               en,
  output logic               frame_done
);
  localparam int BW = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLOAD = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_en;
  logic               r_fd;
  logic [DWELL_W-1:0] r_dwell;
  logic [BW-1:0]      r_blank;
  logic [SEL_W-1:0]   w_nxt;
  logic               w_wrap;
  logic               w_any;
  logic [SEL_W-1:0]   w_cur;
  logic [DWELL_W-1:0] w_dload;
  // forcing cur to the top index makes the IDLE search start at index 0
  assign w_cur   = (r_state == IDLE) ? SEL_W'(NUM_IDX - 1) : r_sel;
  assign w_dload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  scan_next_sel u_next (
    .cur  (w_cur),
    .mask (mask),
    .nxt  (w_nxt),
    .wrap (w_wrap),
    .any  (w_any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_fd    <= 1'b0;
      r_dwell <= '0;
      r_blank <= '0;
    end else begin
      r_fd <= 1'b0;
      case (r_state)
        IDLE: if (run && w_any) begin
          r_sel <= w_nxt;
          if (BLANK_CYC == 0) begin
            r_state <= ACTIVE;
            r_en    <= 1'b1;
            r_dwell <= w_dload;
          end else begin
            r_state <= BLANK;
            r_blank <= BLOAD;
          end
        end
        BLANK: if (r_blank == '0) begin
          r_state <= ACTIVE;
          r_en    <= 1'b1;
          r_dwell <= w_dload;
        end else r_blank <= r_blank - BW'(1);
        ACTIVE: if (r_dwell != '0) r_dwell <= r_dwell - DWELL_W'(1);
        else if (!run || !w_any) begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end else begin
          r_sel <= w_nxt;
          r_fd  <= w_wrap;
          if (BLANK_CYC == 0) r_dwell <= w_dload;
          else begin
            r_state <= BLANK;
            r_en    <= 1'b0;
            r_blank <= BLOAD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign {a1, a0}   = r_sel;
  assign en         = r_en;
  assign frame_done = r_fd;
endmodule
